vector_slide_ctrl: RTL



---
 rtl/vector_slide_pkg.sv | 9 +
 rtl/vector_slide_shifter.sv | 24 ++
 rtl/vector_slide_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/vector_slide_pkg.sv
// vector_slide_pkg: shared types and sizes for the vector slide controller
package vector_slide_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int VECTOR_LANES = 16;
  localparam int WIDTH        = $clog2(VECTOR_LANES);
  typedef enum logic [1:0] {SLIDEUP, SLIDEDOWN, SLIDE1UP, SLIDE1DOWN} slide_op_e;
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;
  typedef logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] vec_t;
endpackage

// File: rtl/vector_slide_shifter.sv
// vector_slide_shifter: log-stage lane shifter producing shifted data and lane-valid mask
module vector_slide_shifter #(
  parameter int DW    = 32,
  parameter int LANES = 16,
  parameter int W     = $clog2(LANES)
) (
  input  logic [LANES-1:0][DW-1:0] data_i,
  input  logic                     dir_i,
  input  logic [W-1:0]             amt_i,
  output logic [LANES-1:0][DW-1:0] data_o,
  output logic [LANES-1:0]         mask_o
);
  logic [LANES*DW-1:0] d [W+1];
  logic [LANES-1:0]    m [W+1];
  assign d[0] = data_i;
  assign m[0] = '1;
  for (genvar s = 0; s < W; s++) begin : g_stage
    localparam int K = 1 << s;
    assign d[s+1] = !amt_i[s] ? d[s] : dir_i ? d[s] >> (K * DW) : d[s] << (K * DW);
    assign m[s+1] = !amt_i[s] ? m[s] : dir_i ? m[s] >> K : m[s] << K;
  end
  assign data_o = d[W];
  assign mask_o = m[W];
endmodule

// File: rtl/vector_slide_ctrl.sv
// vector_slide_ctrl: sequences slide requests through the shifter, merges and holds the result
module vector_slide_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_LANES = 16,
  parameter int WIDTH        = $clog2(VECTOR_LANES)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic                                     req_valid,
  output logic                                     req_ready,
  input  logic [1:0]                               req_op,
  input  logic [31:0]                              req_offset,
  input  logic [DATA_WIDTH-1:0]                    req_scalar,
  input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]  req_src,
  input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]  req_old,
  output logic                                     resp_valid,
  input  logic                                     resp_ready,
  output logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]  resp_data
);
  import vector_slide_pkg::*;
  state_e state_q, state_d;
  slide_op_e op_q;
  logic [31:0] off_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] src_q, old_q, data_q, data_d, sh;
  logic [VECTOR_LANES-1:0] mask;
  logic [WIDTH-1:0] amt;
  logic down, one, oor;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == HOLD;
  assign resp_data  = data_q;
  assign down = op_q inside {SLIDEDOWN, SLIDE1DOWN};
  assign one  = op_q inside {SLIDE1UP, SLIDE1DOWN};
  // any high offset bit pushes every source lane out of the vector
  assign oor  = !one && |off_q[31:WIDTH];
  assign amt  = one ? WIDTH'(1) : off_q[WIDTH-1:0];
  vector_slide_shifter #(.DW(DATA_WIDTH), .LANES(VECTOR_LANES), .W(WIDTH)) u_shift (
    .data_i(src_q),
    .dir_i (down),
    .amt_i (amt),
    .data_o(sh),
    .mask_o(mask)
  );
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < VECTOR_LANES; i++)
      data_d[i] = (mask[i] && !oor) ? sh[i] : down ? '0 : old_q[i];
    if (op_q == SLIDE1UP) data_d[0] = scalar_q;
    if (op_q == SLIDE1DOWN) data_d[VECTOR_LANES-1] = scalar_q;
  end
  always_comb begin
    state_d = flush ? IDLE :
              state_q == IDLE ? (req_valid ? CALC : IDLE) :
              state_q == CALC ? HOLD :
              resp_ready ? IDLE : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= SLIDEUP;
      off_q    <= '0;
      scalar_q <= '0;
      src_q    <= '0;
      old_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready && !flush) begin
        op_q     <= slide_op_e'(req_op);
        off_q    <= req_offset;
        scalar_q <= req_scalar;
        src_q    <= req_src;
        old_q    <= req_old;
      end
      if (flush) data_q <= '0;
      else if (state_q == CALC) data_q <= data_d;
    end
  end
endmodule
